operand_uart_framer: RTL and testbench

OPERAND_UART_FRAMER -- requirements
Module: operand_uart_framer

---
 rtl/operand_uart_framer.sv | 177 +++++++++++++++++
 tb/tb_operand_uart_framer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/operand_uart_framer.sv
// operand_uart_framer
// Two captured operands feed a small ALU (add, sub, mul, xor). On request the
// RES_W-bit result is snapshotted and shipped LSB byte first over a UART line
// (start bit 0, 8 data bits LSB first, stop bit 1).
// Optional build macro UART_PARITY_EN inserts an even-parity bit after the
// data bits of every byte.
module operand_uart_framer #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              save_a,
   input  logic              save_b,
   input  logic [DATA_W-1:0] data_in,
   input  logic [1:0]        op,
   input  logic              tx_start,
   output logic [DATA_W-1:0] q_a,
   output logic [DATA_W-1:0] q_b,
   output logic              busy,
   output logic              done,
   output logic              txd
);

   localparam int RES_W  = 2 * DATA_W;
   localparam int NBYTES = (RES_W + 7) / 8;
   localparam int PAD_W  = NBYTES * 8;
   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NBYTES - 1);

`ifdef UART_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t              state_reg;
   logic [BAUD_W-1:0]   baud_cnt_reg;
   logic [2:0]          bit_cnt_reg;
   logic [BYTE_W-1:0]   byte_cnt_reg;
   // Result snapshot; shifts right one bit per data bit so the current bit is
   // always at index 0 and the next byte lands in the low bits by itself.
   logic [PAD_W-1:0]    shift_reg;
`ifdef UART_PARITY_EN
   logic                parity_reg;
`endif

   logic [RES_W-1:0]    a_ext;
   logic [RES_W-1:0]    b_ext;
   logic [RES_W-1:0]    result_next;
   logic                baud_end;
   logic                last_byte;
   logic                frame_end;
   logic                accept;

   assign a_ext     = RES_W'(q_a);
   assign b_ext     = RES_W'(q_b);
   assign baud_end  = (baud_cnt_reg == BAUD_LAST);
   assign last_byte = (byte_cnt_reg == BYTE_LAST);
   // Final stop bit of the final byte ends on this edge.
   assign frame_end = (state_reg == STOP) && baud_end && last_byte;
   // A request arriving exactly as the last stop bit ends is taken, so frames
   // can run back to back without an idle bit.
   assign accept    = tx_start && ((state_reg == IDLE) || frame_end);

   // Operand registers, captured independently and at any time.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_a <= '0;
         q_b <= '0;
      end else begin
         if (save_a) q_a <= data_in;
         if (save_b) q_b <= data_in;
      end
   end

   // ALU on the current (pre-edge) operand registers.
   always_comb begin
      result_next = '0;
      case (op)
         2'b00:   result_next = a_ext + b_ext;
         2'b01:   result_next = a_ext - b_ext;
         2'b10:   result_next = a_ext * b_ext;
         default: result_next = a_ext ^ b_ext;
      endcase
   end

   // Transmit FSM with baud/bit/byte counters and registered line outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         baud_cnt_reg <= '0;
         bit_cnt_reg  <= '0;
         byte_cnt_reg <= '0;
         shift_reg    <= '0;
`ifdef UART_PARITY_EN
         parity_reg   <= 1'b0;
`endif
         busy         <= 1'b0;
         done         <= 1'b0;
         txd          <= 1'b1;
      end else begin
         done <= frame_end;
         if (state_reg != IDLE)
            baud_cnt_reg <= baud_end ? '0 : baud_cnt_reg + 1'b1;

         if (accept) begin
            state_reg    <= START;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            byte_cnt_reg <= '0;
            shift_reg    <= PAD_W'(result_next);
`ifdef UART_PARITY_EN
            parity_reg   <= 1'b0;
`endif
            busy         <= 1'b1;
            txd          <= 1'b0;
         end else begin
            case (state_reg)
               START: begin
                  if (baud_end) begin
                     state_reg <= DATA;
                     txd       <= shift_reg[0];
                  end
               end
               DATA: begin
                  if (baud_end) begin
                     shift_reg   <= shift_reg >> 1;
                     bit_cnt_reg <= bit_cnt_reg + 3'd1;
`ifdef UART_PARITY_EN
                     parity_reg  <= parity_reg ^ shift_reg[0];
`endif
                     if (bit_cnt_reg == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_reg <= PARITY;
                        txd       <= parity_reg ^ shift_reg[0];
`else
                        state_reg <= STOP;
                        txd       <= 1'b1;
`endif
                     end else begin
                        txd <= shift_reg[1];
                     end
                  end
               end
`ifdef UART_PARITY_EN
               PARITY: begin
                  if (baud_end) begin
                     state_reg <= STOP;
                     txd       <= 1'b1;
                  end
               end
`endif
               STOP: begin
                  if (baud_end) begin
                     if (last_byte) begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                     end else begin
                        state_reg    <= START;
                        byte_cnt_reg <= byte_cnt_reg + 1'b1;
`ifdef UART_PARITY_EN
                        parity_reg   <= 1'b0;
`endif
                        txd          <= 1'b0;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_operand_uart_framer.sv
// Testbench for operand_uart_framer (DATA_W=8, CLKS_PER_BIT=4).
// Honours UART_PARITY_EN the same way as the design.
module tb_operand_uart_framer;

   localparam int DW    = 8;
   localparam int CPB   = 4;
   localparam int NB    = 2;
`ifdef UART_PARITY_EN
   localparam int FRAME = 11;
`else
   localparam int FRAME = 10;
`endif
   localparam int TOTAL = NB * FRAME * CPB;

   logic          clk      = 1'b0;
   logic          reset    = 1'b1;
   logic          save_a   = 1'b0;
   logic          save_b   = 1'b0;
   logic [DW-1:0] data_in  = '0;
   logic [1:0]    op       = 2'b00;
   logic          tx_start = 1'b0;
   logic [DW-1:0] q_a;
   logic [DW-1:0] q_b;
   logic          busy;
   logic          done;
   logic          txd;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   operand_uart_framer #(
      .DATA_W       (DW),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .save_a   (save_a),
      .save_b   (save_b),
      .data_in  (data_in),
      .op       (op),
      .tx_start (tx_start),
      .q_a      (q_a),
      .q_b      (q_b),
      .busy     (busy),
      .done     (done),
      .txd      (txd)
   );

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [1:0]  op;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference arithmetic on plain integers, result modulo 2^16.
   function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic [1:0] o);
      int unsigned ia;
      int unsigned ib;
      int unsigned r;
      ia = 32'(a);
      ib = 32'(b);
      case (o)
         2'b00:   r = ia + ib;
         2'b01:   r = ia + 65536 - ib;
         2'b10:   r = ia * ib;
         default: r = ia ^ ib;
      endcase
      return r[15:0];
   endfunction

   // Expected line level for bit slot idx of the whole transmission.
   function automatic logic exp_bit(input logic [15:0] val, input int idx);
      int byte_i;
      int pos;
      logic [7:0] b;
      byte_i = idx / FRAME;
      pos    = idx % FRAME;
      if (byte_i >= NB) return 1'b1;
      b = val[byte_i*8 +: 8];
      if (pos == 0) return 1'b0;
      if (pos <= 8) return b[pos-1];
`ifdef UART_PARITY_EN
      if (pos == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   // Load operands, then pulse tx_start; returns at the negedge after the accepting edge.
   task automatic start_tx(input logic [7:0] a, input logic [7:0] b, input logic [1:0] o);
      @(negedge clk); data_in = a; save_a = 1'b1;
      @(negedge clk); save_a = 1'b0; data_in = b; save_b = 1'b1;
      @(negedge clk); save_b = 1'b0; op = o; tx_start = 1'b1;
      @(negedge clk); tx_start = 1'b0;
   endtask

   // Follow one transmission cycle by cycle from its first busy cycle.
   task automatic watch(input string tag, input logic [15:0] exp_val, input bit chain,
                        input logic [1:0] next_op, input bit interfere);
      int txd_bad;
      int busy_bad;
      int early_done;
      int bi;
      int pos;
      logic [15:0] rx;
      txd_bad = 0; busy_bad = 0; early_done = 0; rx = '0;
      for (int k = 0; k < TOTAL; k++) begin
         bi  = k / CPB;
         pos = bi % FRAME;
         if (txd !== exp_bit(exp_val, bi)) txd_bad++;
         if (busy !== 1'b1) busy_bad++;
         if (k > 0 && done !== 1'b0) early_done++;
         if ((k % CPB) == (CPB / 2) && pos >= 1 && pos <= 8)
            rx[(bi / FRAME) * 8 + pos - 1] = txd;
         if (interfere && k == 20) begin tx_start = 1'b1; save_a = 1'b1; data_in = 8'h11; end
         if (interfere && k == 21) begin tx_start = 1'b0; save_a = 1'b0; end
         if (interfere && k == 30) op = ~op;
         if (chain && k == TOTAL - 1) begin tx_start = 1'b1; op = next_op; end
         @(negedge clk);
      end
      check({tag, " txd_stream"}, 32'(txd_bad), 32'd0);
      check({tag, " value"}, 32'(rx), 32'(exp_val));
      check({tag, " busy_during"}, 32'(busy_bad), 32'd0);
      check({tag, " done_early"}, 32'(early_done), 32'd0);
      check({tag, " done_pulse"}, 32'(done), 32'd1);
      if (chain) begin
         check({tag, " b2b_busy"}, 32'(busy), 32'd1);
         check({tag, " b2b_start"}, 32'(txd), 32'd0);
         tx_start = 1'b0;
      end else begin
         check({tag, " busy_end"}, 32'(busy), 32'd0);
         @(negedge clk);
         check({tag, " done_width"}, 32'(done), 32'd0);
      end
      $display("TX %s exp=%04h rx=%04h", tag, exp_val, rx);
   endtask

   initial begin
      int bad;
      logic [7:0]  ra;
      logic [7:0]  rb;
      logic [1:0]  ro;

      vecs[0] = '{8'hC8, 8'h64, 2'b00, 16'h012C};
      vecs[1] = '{8'hFF, 8'hFF, 2'b10, 16'hFE01};
      vecs[2] = '{8'h05, 8'h07, 2'b01, 16'hFFFE};
      vecs[3] = '{8'hA5, 8'h3C, 2'b11, 16'h0099};
      vecs[4] = '{8'hFF, 8'hFF, 2'b00, 16'h01FE};
      vecs[5] = '{8'h00, 8'h01, 2'b01, 16'hFFFF};
      vecs[6] = '{8'h0F, 8'h10, 2'b10, 16'h00F0};

      // Reset state
      repeat (2) @(negedge clk);
      check("rst q_a", 32'(q_a), 32'd0);
      check("rst q_b", 32'(q_b), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst txd", 32'(txd), 32'd1);
      reset = 1'b0;
      @(negedge clk);
      check("idle txd", 32'(txd), 32'd1);

      // Table of fixed vectors
      for (int i = 0; i < 7; i++) begin
         start_tx(vecs[i].a, vecs[i].b, vecs[i].op);
         watch("tbl", vecs[i].exp, 1'b0, 2'b00, 1'b0);
      end

      // Back-to-back: second request lands on the final stop edge with op=mul
      start_tx(8'hC8, 8'h64, 2'b00);
      watch("b2b1", 16'h012C, 1'b1, 2'b10, 1'b0);
      watch("b2b2", 16'h4E20, 1'b0, 2'b00, 1'b0);

      // tx_start, save_a and op change while busy
      start_tx(8'hC8, 8'h64, 2'b00);
      watch("intf", 16'h012C, 1'b0, 2'b00, 1'b1);
      check("intf q_a", 32'(q_a), 32'h11);
      bad = 0;
      repeat (3 * CPB) begin
         @(negedge clk);
         if (busy !== 1'b0 || txd !== 1'b1) bad++;
      end
      check("intf no_second", 32'(bad), 32'd0);

      // Reset during data bit 0 of byte 0 (line low at that point)
      start_tx(8'hC8, 8'h64, 2'b00);
      repeat (CPB + 1) @(negedge clk);
      check("pre_rst txd", 32'(txd), 32'd0);
      reset = 1'b1;
      #1;
      check("mid_rst txd", 32'(txd), 32'd1);
      check("mid_rst busy", 32'(busy), 32'd0);
      check("mid_rst done", 32'(done), 32'd0);
      check("mid_rst q_a", 32'(q_a), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      bad = 0;
      repeat (40) begin
         @(negedge clk);
         if (txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
      end
      check("post_rst quiet", 32'(bad), 32'd0);

      // Randomized transactions against the reference model
      for (int i = 0; i < 20; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         ro = 2'($urandom_range(0, 3));
         start_tx(ra, rb, ro);
         watch("rnd", model(ra, rb, ro), 1'b0, 2'b00, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
